// File: rtl/decoder_stream_pkg.sv
// rtl/decoder_stream_pkg.sv - mode encodings and the shared code-decode function.
package decoder_stream_pkg;

  localparam logic [1:0] MODE_REVERSE = 2'd0;
  localparam logic [1:0] MODE_ONEHOT  = 2'd1;
  localparam logic [1:0] MODE_THERMO  = 2'd2;
  localparam logic [1:0] MODE_BINARY  = 2'd3;

  // Working width of the decode; callers slice the low OUT_W bits of y.
  localparam int DEC_W = 32;

  typedef struct packed {
    logic             err;
    logic [DEC_W-1:0] y;
  } dec_t;

  function automatic dec_t decode_code(
    input logic [1:0]       mode,
    input logic [DEC_W-1:0] a,
    input int unsigned      in_w,
    input int unsigned      out_w
  );
    dec_t             r;
    logic [DEC_W-1:0] m;
    m     = {DEC_W{1'b1}} >> (DEC_W - in_w);
    r.err = 1'b0;
    r.y   = '0;
    case (mode)
      MODE_REVERSE: begin
        r.y   = m - a;
        r.err = (r.y >> out_w) != '0;
      end
      MODE_ONEHOT: begin
        r.err = a >= out_w;
        r.y   = {{(DEC_W-1){1'b0}}, 1'b1} << a;
      end
      MODE_THERMO: begin
        r.err = a > out_w;
        r.y   = ~({DEC_W{1'b1}} << a);
      end
      default: begin
        r.y   = a;
        r.err = (a >> out_w) != '0;
      end
    endcase
    if (r.err) r.y = '1;
    return r;
  endfunction

endpackage

// File: rtl/decoder_skid.sv
// rtl/decoder_skid.sv - 2-entry valid/ready skid buffer (output register plus skid register).
module decoder_skid #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_skid_valid;
  logic [W-1:0] r_skid_data;
  logic         r_in_ready;
  logic         w_accept;
  logic         w_load_out;
  logic         w_skid_valid_nxt;

  assign w_accept   = in_valid && r_in_ready;
  // The output register can take a new value when empty or draining this edge.
  assign w_load_out = !r_out_valid || out_ready;

  always_comb begin
    w_skid_valid_nxt = 1'b0;
    if (w_load_out) w_skid_valid_nxt = r_skid_valid && w_accept;
    else            w_skid_valid_nxt = r_skid_valid || w_accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      if (w_load_out) begin
        if (r_skid_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_skid_data;
        end else begin
          r_out_valid <= w_accept;
          if (w_accept) r_out_data <= in_data;
        end
      end
      if (w_accept && (r_skid_valid || !w_load_out)) r_skid_data <= in_data;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: rtl/decoder_stream.sv
// rtl/decoder_stream.sv - registered multi-mode code decoder with skid buffer and error counter.
module decoder_stream
  import decoder_stream_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_y,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_cnt
);

  dec_t             w_dec;
  logic             w_in_ready;
  logic             w_accept;
  logic [OUT_W:0]   w_out_data;
  logic [CNT_W-1:0] r_err_cnt;

  always_comb w_dec = decode_code(in_mode, DEC_W'(in_a), IN_W, OUT_W);

  decoder_skid #(
    .W(OUT_W + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (w_in_ready),
    .in_data  ({w_dec.err, w_dec.y[OUT_W-1:0]}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (w_out_data)
  );

  assign in_ready         = w_in_ready;
  assign w_accept         = in_valid && w_in_ready;
  assign {out_err, out_y} = w_out_data;

  // Clear wins over a simultaneous erroring accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (clr_cnt) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_dec.err && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_decoder_stream.sv
// tb/tb_decoder_stream.sv - scoreboard bench for decoder_stream with a behavioural decode model.
module tb_decoder_stream;

  localparam int IN_W  = 4;
  localparam int OUT_W = 6;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_a = '0;
  logic [1:0]       in_mode = '0;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_y;
  logic             out_err;
  logic [CNT_W-1:0] err_cnt;
  logic             clr_cnt = 1'b0;

  int             nchecks = 0;
  int             nerrors = 0;
  int             cyc = 0;
  int             mcnt = 0;
  int             bp_mode = 0;
  bit             lat_chk = 0;
  logic [OUT_W:0] q_exp[$];
  int             q_cyc[$];

  decoder_stream #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_err  (out_err),
    .err_cnt  (err_cnt),
    .clr_cnt  (clr_cnt)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Back-pressure source: 0 = always ready, 1 = stalled, 2 = random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [OUT_W:0] ref_dec(input int m, input int a);
    int mx;
    int lim;
    int y;
    bit e;
    mx  = (1 << IN_W) - 1;
    lim = 1 << OUT_W;
    y   = 0;
    e   = 0;
    case (m)
      0: begin y = mx - a; e = (y >= lim); end
      1: begin e = (a >= OUT_W); y = e ? 0 : (1 << a); end
      2: begin e = (a > OUT_W); y = (1 << a) - 1; end
      default: begin y = a; e = (a >= lim); end
    endcase
    if (e) y = lim - 1;
    return {e, y[OUT_W-1:0]};
  endfunction

  task automatic push(input logic [1:0] m, input logic [IN_W-1:0] a, input logic clr);
    logic [OUT_W:0] r;
    r = ref_dec(int'(m), int'(a));
    q_exp.push_back(r);
    q_cyc.push_back(cyc + 1);
    if (clr) mcnt = 0;
    else if (r[OUT_W] && mcnt < (1 << CNT_W) - 1) mcnt++;
  endtask

  task automatic send(input logic [1:0] m, input logic [IN_W-1:0] a, input logic clr);
    bit done;
    done     = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_mode  = m;
    clr_cnt  = clr;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        push(m, a, clr);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    nchecks++;
    if (!done) begin
      nerrors++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected acceptance at cycle %0d", cyc);
    end else begin
      chk("err_cnt", 32'(err_cnt), 32'(mcnt));
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 500 && q_exp.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_remaining", 32'(q_exp.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on each output transfer and checks hold stability.
  initial begin
    bit             hold;
    logic [OUT_W-1:0] hy;
    logic           he;
    logic [OUT_W:0] e;
    int             ac;
    hold = 0;
    hy   = '0;
    he   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0;
      end else begin
        if (hold) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_y", 32'(out_y), 32'(hy));
          chk("hold_err", 32'(out_err), 32'(he));
        end
        if (out_valid && out_ready) begin
          nchecks++;
          if (q_exp.size() == 0) begin
            nerrors++;
            $display("FAIL spurious_output: got y=%0h err=%0b expected no output at cycle %0d", out_y, out_err, cyc);
          end else begin
            e  = q_exp.pop_front();
            ac = q_cyc.pop_front();
            if (out_y !== e[OUT_W-1:0] || out_err !== e[OUT_W]) begin
              nerrors++;
              $display("FAIL out_data: got y=%0h err=%0b expected y=%0h err=%0b at cycle %0d",
                       out_y, out_err, e[OUT_W-1:0], e[OUT_W], cyc);
            end
            if (lat_chk) chk("latency_cycle", 32'(cyc), 32'(ac));
          end
        end
        hold = out_valid && !out_ready;
        hy   = out_y;
        he   = out_err;
      end
    end
  end

  initial begin
    bit pushed;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("in_ready_after_edge", 32'(in_ready), 32'd1);

    // REVERSE sweep, back-to-back with 1-cycle latency
    lat_chk = 1;
    for (int a = 0; a < 16; a++) send(2'd0, 4'(a), 1'b0);
    wait_drain();
    lat_chk = 0;
    chk("sweep_err_cnt", 32'(err_cnt), 32'd0);

    // ONEHOT and THERMO boundaries
    send(2'd1, 4'd3, 1'b0);
    send(2'd1, 4'd6, 1'b0);
    send(2'd1, 4'd15, 1'b0);
    chk("onehot_err_cnt", 32'(err_cnt), 32'd2);
    send(2'd2, 4'd0, 1'b0);
    send(2'd2, 4'd6, 1'b0);
    send(2'd2, 4'd7, 1'b0);
    send(2'd3, 4'd9, 1'b0);
    wait_drain();

    // Saturation then clear-with-error priority
    for (int k = 0; k < 5; k++) send(2'd1, 4'(6 + k), 1'b0);
    chk("err_cnt_sat", 32'(err_cnt), 32'd3);
    send(2'd1, 4'd12, 1'b1);
    chk("err_cnt_clr_prio", 32'(err_cnt), 32'd0);
    wait_drain();

    // Back-pressure: 14 held, 13 in skid, 3 refused until release
    bp_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send(2'd0, 4'd1, 1'b0);
    send(2'd0, 4'd2, 1'b0);
    in_valid = 1'b1;
    in_a     = 4'd3;
    in_mode  = 2'd0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_14", 32'(out_y), 32'd14);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    bp_mode = 0;
    pushed  = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_no_gap", 32'(out_valid), 32'd1);
      if (in_ready && !pushed) begin
        push(2'd0, 4'd3, 1'b0);
        pushed = 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("bp_third_taken", 32'(pushed), 32'd1);
    wait_drain();

    // Randomized traffic under random back-pressure
    bp_mode = 2;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 19) == 0));
    end
    bp_mode = 0;
    wait_drain();

    // Reset with both entries full
    bp_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send(2'd1, 4'd9, 1'b0);
    send(2'd3, 4'd1, 1'b0);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_y", 32'(out_y), 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    q_exp.delete();
    q_cyc.delete();
    mcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    bp_mode = 0;
    #1;
    chk("postrst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("postrst_in_ready_high", 32'(in_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'b0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
